// File: rtl/incr_unit_if.sv
// Memory-port and traversal handshake bundle for the Nock increment unit.
// The slave side is the unit itself; the master side is traversal plus memory.
interface incr_unit_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] module_address;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] read_data1;
  logic                  mem_execute;
  logic [ADDR_WIDTH-1:0] address1;
  logic [1:0]            mem_func;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  module_finished;
  logic [3:0]            execute_return_sys_func;
  logic [3:0]            execute_return_state;
  logic [7:0]            error;

  modport master (
    output start, module_address,
    output mem_ready, read_data1,
    input  mem_execute, address1, mem_func,
    input  write_data, module_finished,
    input  execute_return_sys_func,
    input  execute_return_state, error
  );

  modport slave (
    input  start, module_address,
    input  mem_ready, read_data1,
    output mem_execute, address1, mem_func,
    output write_data, module_finished,
    output execute_return_sys_func,
    output execute_return_state, error
  );
endinterface

// File: rtl/incr_unit.sv
// Nock opcode-4 increment unit: read the stack cell, bump its atom
// operand, write it back, then hand control back to traversal.
module incr_unit #(
  parameter int ADDR_WIDTH = 11,
  parameter int NOUN_WIDTH = 28,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = TAG_WIDTH + 2 * NOUN_WIDTH
) (
  input logic        clk,
  input logic        rst,
  incr_unit_if.slave bus
);

  localparam int NW = NOUN_WIDTH;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_REQ  = 4'd1;
  localparam logic [3:0] S_RD_WAIT = 4'd2;
  localparam logic [3:0] S_CHECK   = 4'd3;
  localparam logic [3:0] S_WR_REQ  = 4'd4;
  localparam logic [3:0] S_WR_WAIT = 4'd5;
  localparam logic [3:0] S_DONE    = 4'd6;
  localparam logic [3:0] S_FAIL    = 4'd7;
  localparam logic [3:0] S_HOLD    = 4'd8;

  localparam logic [3:0] SF_TRAVERSE = 4'd2;
  localparam logic [3:0] ST_POP      = 4'd2;
  localparam logic [3:0] SF_EXECUTE  = 4'd3;
  localparam logic [3:0] ST_ERROR    = 4'hF;

  localparam logic [NW-1:0] NIL    = '1;
  localparam logic [NW-1:0] NIL_M1 = {{(NW-1){1'b1}}, 1'b0};
  localparam logic [NW-1:0] OP_INC = NW'(4);

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  abort_q, abort_d;
  logic [7:0]            err_q, err_d;
  logic [3:0]            sf_q, sf_d;
  logic [3:0]            st_q, st_d;

  logic [NW-1:0] tel;
  logic [NW-1:0] hed;
  logic          tel_cell;
  logic          quit;
  logic          unused_tag;

  assign tel        = word_q[NW-1:0];
  assign hed        = word_q[2*NW-1:NW];
  assign tel_cell   = word_q[2*NW];
  assign unused_tag = ^word_q[DATA_WIDTH-1:2*NW+1];

  // Traversal dropping start mid-flight: finish the bus op, then go quiet.
  assign quit = abort_q | ~bus.start;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    abort_d = abort_q;
    err_d   = err_q;
    sf_d    = sf_q;
    st_d    = st_q;
    unique case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (bus.start) begin
          addr_d  = bus.module_address;
          sf_d    = 4'd0;
          st_d    = 4'd0;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        abort_d = quit;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        abort_d = quit;
        if (bus.mem_ready) begin
          word_d  = bus.read_data1;
          state_d = quit ? S_IDLE : S_CHECK;
        end
      end
      S_CHECK: begin
        if (quit) begin
          state_d = S_IDLE;
        end else if (hed != OP_INC) begin
          err_d   = 8'h03;
          state_d = S_FAIL;
        end else if (tel_cell) begin
          err_d   = 8'h01;
          state_d = S_FAIL;
        end else if (tel == NIL_M1) begin
          err_d   = 8'h02;
          state_d = S_FAIL;
        end else begin
          state_d = S_WR_REQ;
        end
        if (!quit && state_d == S_FAIL) begin
          sf_d = SF_EXECUTE;
          st_d = ST_ERROR;
        end
      end
      S_WR_REQ: begin
        abort_d = quit;
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        abort_d = quit;
        if (bus.mem_ready) begin
          if (quit) begin
            state_d = S_IDLE;
          end else begin
            sf_d    = SF_TRAVERSE;
            st_d    = ST_POP;
            state_d = S_DONE;
          end
        end
      end
      S_DONE, S_FAIL: state_d = S_HOLD;
      S_HOLD: begin
        if (!bus.start) begin
          err_d   = 8'h00;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= '0;
      sf_q    <= '0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      sf_q    <= sf_d;
      st_q    <= st_d;
    end
  end

  logic rd_req;
  logic wr_req;

  assign rd_req = (state_q == S_RD_REQ);
  assign wr_req = (state_q == S_WR_REQ);

  assign bus.mem_execute = rd_req | wr_req;
  assign bus.mem_func    = rd_req ? 2'd1 :
                           wr_req ? 2'd2 : 2'd0;
  assign bus.address1    = (rd_req | wr_req) ? addr_q : '0;
  // Result cell is a plain atom: flags cleared, tel slot parked at NIL.
  assign bus.write_data  = wr_req ?
    {TAG_WIDTH'(0), tel + NW'(1), NIL} : '0;

  assign bus.module_finished =
    (state_q == S_DONE) | (state_q == S_FAIL);
  assign bus.execute_return_sys_func = sf_q;
  assign bus.execute_return_state    = st_q;
  assign bus.error                   = err_q;

endmodule

// File: tb/tb_incr_unit.sv
// Directed bench for incr_unit: zero-wait and stalled memory,
// every error path, traversal abort and reset in mid-write.
module tb_incr_unit;

  localparam logic [27:0] NIL = 28'hFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  incr_unit_if #(.ADDR_WIDTH(11), .DATA_WIDTH(64)) bus ();

  incr_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [63:0] mem [0:2047];
  int          rd_lat = 0;
  int          wr_lat = 0;
  int          n_get = 0;
  int          n_set = 0;
  int          clash = 0;
  logic [10:0] last_waddr = '0;
  logic [63:0] last_wdata = '0;
  bit          busy = 0;
  int          wcnt = 0;
  logic [10:0] pa = '0;

  // Memory responder: ready comes the cycle after the strobe plus lat.
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    if (bus.mem_execute && bus.module_finished) clash++;
    if (rst) begin
      busy = 0;
    end else begin
      if (busy) begin
        if (wcnt == 0) begin
          bus.mem_ready  = 1'b1;
          bus.read_data1 = mem[pa];
          busy = 0;
        end else begin
          wcnt--;
        end
      end
      if (bus.mem_execute) begin
        busy = 1;
        pa   = bus.address1;
        if (bus.mem_func == 2'd1) begin
          n_get++;
          wcnt = rd_lat;
        end else begin
          n_set++;
          wcnt = wr_lat;
          last_waddr = bus.address1;
          last_wdata = bus.write_data;
          mem[bus.address1] = bus.write_data;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [10:0] a,
                        input logic [7:0]  tg,
                        input logic [27:0] hd,
                        input logic [27:0] tl,
                        input logic [7:0]  xerr,
                        input logic [27:0] xres,
                        input int          xlat);
    int n;
    bit fin;
    bit ok;
    ok = (xerr == 8'h00);
    mem[a] = {tg, hd, tl};
    n_get = 0;
    n_set = 0;
    clash = 0;
    bus.module_address = a;
    bus.start = 1'b1;
    n = 0;
    fin = 0;
    while (!fin && n < 200) begin
      cyc();
      n++;
      if (bus.module_finished) fin = 1;
    end
    check("finished", 64'(fin), 64'd1);
    check("latency", 64'(n + 1), 64'(xlat));
    check("gets", 64'(n_get), 64'd1);
    check("sets", 64'(n_set), ok ? 64'd1 : 64'd0);
    check("error", 64'(bus.error), 64'(xerr));
    check("ret_sys_func", 64'(bus.execute_return_sys_func),
          ok ? 64'd2 : 64'd3);
    check("ret_state", 64'(bus.execute_return_state),
          ok ? 64'd2 : 64'hF);
    if (ok) begin
      check("waddr", 64'(last_waddr), 64'(a));
      check("wdata", last_wdata, {8'h00, xres, NIL});
    end
    cyc();
    check("pulse_len", 64'(bus.module_finished), 64'd0);
    check("err_hold", 64'(bus.error), 64'(xerr));
    bus.start = 1'b0;
    cyc();
    check("err_clear", 64'(bus.error), 64'd0);
    check("strobe_vs_fin", 64'(clash), 64'd0);
  endtask

  initial begin
    int n;
    int fins;
    bus.start = 1'b0;
    bus.module_address = '0;
    bus.mem_ready = 1'b0;
    bus.read_data1 = '0;
    repeat (3) cyc();
    check("rst_ctl", 64'({bus.mem_execute, bus.mem_func,
          bus.address1, bus.module_finished}), 64'd0);
    check("rst_ret", 64'({bus.execute_return_sys_func,
          bus.execute_return_state, bus.error}), 64'd0);
    check("rst_wdata", bus.write_data, 64'd0);
    rst = 1'b0;
    cyc();

    run_op(11'h010, 8'hC0, 28'd4, 28'd41, 8'h00, 28'd42, 7);
    run_op(11'h011, 8'hC1, 28'd4, 28'h055, 8'h01, 28'd0, 5);
    run_op(11'h012, 8'hC0, 28'd4, 28'hFFFFFFE, 8'h02, 28'd0, 5);
    run_op(11'h013, 8'hC0, 28'd4, 28'hFFFFFFD, 8'h00,
           28'hFFFFFFE, 7);
    run_op(11'h014, 8'hC0, 28'd5, 28'd1, 8'h03, 28'd0, 5);
    run_op(11'h015, 8'hC1, 28'd5, 28'd1, 8'h03, 28'd0, 5);
    run_op(11'h7FE, 8'h80, 28'd4, 28'd0, 8'h00, 28'd1, 7);

    rd_lat = 10;
    wr_lat = 4;
    run_op(11'h016, 8'hC0, 28'd4, 28'd1000, 8'h00, 28'd1001, 21);
    rd_lat = 0;
    wr_lat = 0;

    // Traversal abort while the read is in flight.
    mem[11'h030] = {8'hC0, 28'd4, 28'd9};
    n_get = 0;
    n_set = 0;
    bus.module_address = 11'h030;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    fins = 0;
    repeat (12) begin
      cyc();
      if (bus.module_finished) fins++;
    end
    check("abort_fin", 64'(fins), 64'd0);
    check("abort_get", 64'(n_get), 64'd1);
    check("abort_set", 64'(n_set), 64'd0);
    check("abort_mem", mem[11'h030], {8'hC0, 28'd4, 28'd9});

    // Reset while waiting on the write acknowledge.
    wr_lat = 5;
    n_set = 0;
    mem[11'h020] = {8'hC0, 28'd4, 28'd100};
    bus.module_address = 11'h020;
    bus.start = 1'b1;
    n = 0;
    while (bus.mem_func != 2'd2 && n < 50) begin
      cyc();
      n++;
    end
    check("saw_set", 64'(bus.mem_func), 64'd2);
    cyc();
    rst = 1'b1;
    bus.start = 1'b0;
    cyc();
    check("mid_rst_ctl", 64'({bus.mem_execute, bus.mem_func,
          bus.address1, bus.module_finished}), 64'd0);
    check("mid_rst_ret", 64'({bus.execute_return_sys_func,
          bus.execute_return_state, bus.error}), 64'd0);
    check("mid_rst_wdata", bus.write_data, 64'd0);
    rst = 1'b0;
    repeat (8) cyc();
    check("no_wr_after_rst", 64'(n_set), 64'd1);
    wr_lat = 0;
    run_op(11'h021, 8'hC0, 28'd4, 28'd7, 8'h00, 28'd8, 7);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
